// File: rtl/mems_stage_sequencer_pkg.sv
// Shared types and sizing for the MEMS stage sequencer.
//   NUM_STAGES : stages per pass; stage code NUM_STAGES means "finished"
//   STAGE_W    : stage code width (NUM_STAGES <= 2**STAGE_W-1)
//   BEAT_W     : beat counter / beats_per_stage width
//   WR_LAT     : read-to-write latency in cycles (>= 1)
package mems_seq_pkg;

  localparam int unsigned NUM_STAGES = 11;
  localparam int unsigned STAGE_W    = 4;
  localparam int unsigned BEAT_W     = 8;
  localparam int unsigned WR_LAT     = 3;

  typedef logic [STAGE_W-1:0] stage_t;
  typedef logic [BEAT_W-1:0]  beat_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/mems_stage_sequencer_if.sv
// Control/status bundle between the layer controller (master) and the stage sequencer (slave).
//   start, abort, beats_per_stage, stall : controller -> sequencer
//   rd_stage, rd_beat, rd_valid          : read-side beat stream
//   wr_stage, wr_valid                   : write-side replay, WR_LAT cycles behind the read side
//   busy, done                           : pass status
interface mems_stage_sequencer_if;

  logic                  start;
  logic                  abort;
  mems_seq_pkg::beat_t   beats_per_stage;
  logic                  stall;
  mems_seq_pkg::stage_t  rd_stage;
  mems_seq_pkg::beat_t   rd_beat;
  logic                  rd_valid;
  mems_seq_pkg::stage_t  wr_stage;
  logic                  wr_valid;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, beats_per_stage, stall,
    input  rd_stage, rd_beat, rd_valid, wr_stage, wr_valid, busy, done
  );

  modport slave (
    input  start, abort, beats_per_stage, stall,
    output rd_stage, rd_beat, rd_valid, wr_stage, wr_valid, busy, done
  );

endinterface

// File: rtl/mems_stage_delay.sv
// Depth-deep shift register of {valid, stage} that replays the read beat stream on the write side.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous clear of every entry (and of the held output stage)
//   in_valid   : read beat issued this cycle
//   in_stage   : stage of that beat
//   out_valid  : tail entry is valid (write beat due)
//   out_stage  : stage of the most recent valid tail entry; holds while the tail is empty
//   pending    : some valid entry will still be in the line after the coming edge
module mems_stage_delay #(
  parameter int unsigned Depth = 3,
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [Width-1:0] in_stage,
  output logic             out_valid,
  output logic [Width-1:0] out_stage,
  output logic             pending
);

  logic [Depth-1:0]            valid_q, valid_d;
  logic [Depth-1:0][Width-1:0] stage_q, stage_d;

  // Entry i loads from chain slot i; slot 0 is the incoming beat.
  logic [Depth:0]              v_chain;
  logic [Depth:0][Width-1:0]   s_chain;

  always_comb begin
    v_chain = {valid_q, in_valid};
    s_chain = {stage_q, in_stage};
    valid_d = '0;
    stage_d = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      valid_d[i] = v_chain[i];
      stage_d[i] = s_chain[i];
    end
    // The tail stage only follows valid beats so wr_stage holds across gaps.
    if (!v_chain[Depth-1]) begin
      stage_d[Depth-1] = stage_q[Depth-1];
    end
    if (flush) begin
      valid_d = '0;
      stage_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      stage_q <= '0;
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
    end
  end

  assign out_valid = valid_q[Depth-1];
  assign out_stage = stage_q[Depth-1];
  // Slots 0..Depth-1 of the chain are exactly what survives the next shift.
  assign pending   = |v_chain[Depth-1:0];

endmodule

// File: rtl/mems_stage_sequencer.sv
// Walks the read side through stages 0..NUM_STAGES-1 (len beats each, with stalls), replays the
// stream on the write side WR_LAT cycles later, and reports busy/done. Abort returns to idle.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : mems_stage_sequencer_if.slave (start/abort/beats_per_stage/stall in; stage streams and
//         busy/done out)
module mems_stage_sequencer
  import mems_seq_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  mems_stage_sequencer_if.slave        bus
);

  localparam stage_t LastStage = STAGE_W'(NUM_STAGES - 1);
  localparam stage_t EndStage  = STAGE_W'(NUM_STAGES);

  state_e state_q, state_d;
  beat_t  len_q, len_d;
  stage_t rd_stage_q, rd_stage_d;
  beat_t  rd_beat_q, rd_beat_d;
  logic   rd_valid;
  logic   flush;
  logic   pending;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_stage_d = rd_stage_q;
    rd_beat_d  = rd_beat_q;
    rd_valid   = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StRun;
          len_d      = (bus.beats_per_stage == '0) ? BEAT_W'(1) : bus.beats_per_stage;
          rd_stage_d = '0;
          rd_beat_d  = '0;
        end
      end
      StRun: begin
        if (!bus.stall) begin
          rd_valid = 1'b1;
          if (rd_beat_q == len_q - BEAT_W'(1)) begin
            rd_beat_d = '0;
            if (rd_stage_q == LastStage) begin
              rd_stage_d = EndStage;
              state_d    = StDrain;
            end else begin
              rd_stage_d = rd_stage_q + STAGE_W'(1);
            end
          end else begin
            rd_beat_d = rd_beat_q + BEAT_W'(1);
          end
        end
      end
      StDrain: begin
        if (!pending) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Line is already empty; flushing here zeroes the held wr_stage for idle.
        state_d    = StIdle;
        rd_stage_d = '0;
        rd_beat_d  = '0;
        flush      = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort wins over everything, including a start seen in idle.
    if (bus.abort) begin
      state_d    = StIdle;
      len_d      = len_q;
      rd_stage_d = '0;
      rd_beat_d  = '0;
      flush      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= BEAT_W'(1);
      rd_stage_q <= '0;
      rd_beat_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_stage_q <= rd_stage_d;
      rd_beat_q  <= rd_beat_d;
    end
  end

  mems_stage_delay #(
    .Depth (WR_LAT),
    .Width (STAGE_W)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (rd_valid),
    .in_stage  (rd_stage_q),
    .out_valid (bus.wr_valid),
    .out_stage (bus.wr_stage),
    .pending   (pending)
  );

  assign bus.rd_stage = rd_stage_q;
  assign bus.rd_beat  = rd_beat_q;
  assign bus.rd_valid = rd_valid;
  assign bus.busy     = (state_q == StRun) || (state_q == StDrain);
  assign bus.done     = (state_q == StDone);

endmodule

// File: tb/tb_mems_stage_sequencer.sv
module tb_mems_stage_sequencer;
  import mems_seq_pkg::*;

  localparam int MaxC = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mems_stage_sequencer_if bus ();

  mems_stage_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle-indexed expectations; cycle 0 is the cycle in which start is high.
  int m_rdv[MaxC], m_rds[MaxC], m_rdb[MaxC], m_stall[MaxC];
  int m_wrv[MaxC], m_wrs[MaxC], m_busy[MaxC], m_done[MaxC];

  typedef struct {
    int bps;
    int stall_stage;
    int stall_beat;
    int stall_cycles;
    int repulse_cycle;   // -1: no second start
    int exp_done;        // hand-computed cycle of the done pulse
  } vec_t;

  // Expected streams derived from the behavioural description: beats in stage/beat order,
  // stall cycles inserted before the chosen beat, write side = read side delayed WR_LAT.
  task automatic build_model(input vec_t v);
    int len, k, last, dn, hold;
    for (int c = 0; c < MaxC; c++) begin
      m_rdv[c] = 0; m_rds[c] = 0; m_rdb[c] = 0; m_stall[c] = 0;
      m_wrv[c] = 0; m_wrs[c] = 0; m_busy[c] = 0; m_done[c] = 0;
    end
    len = (v.bps == 0) ? 1 : v.bps;
    k = 1;
    for (int s = 0; s < int'(NUM_STAGES); s++) begin
      for (int b = 0; b < len; b++) begin
        if (s == v.stall_stage && b == v.stall_beat) begin
          for (int n = 0; n < v.stall_cycles; n++) begin
            m_rds[k] = s; m_rdb[k] = b; m_stall[k] = 1; m_busy[k] = 1; k++;
          end
        end
        m_rdv[k] = 1; m_rds[k] = s; m_rdb[k] = b; m_busy[k] = 1; k++;
      end
    end
    last = k - 1;
    dn = last + int'(WR_LAT) + 1;
    for (int c = last + 1; c <= dn; c++) begin
      m_rds[c]  = NUM_STAGES;
      m_busy[c] = (c < dn) ? 1 : 0;
      m_done[c] = (c == dn) ? 1 : 0;
    end
    hold = 0;
    for (int c = 1; c <= dn; c++) begin
      if (c > int'(WR_LAT) && m_rdv[c - int'(WR_LAT)] == 1) begin
        m_wrv[c] = 1;
        hold = m_rds[c - int'(WR_LAT)];
      end
      m_wrs[c] = hold;
    end
  endtask

  task automatic check_outputs(input string tag, input int k);
    check($sformatf("%s c%0d rd_valid", tag, k), int'(bus.rd_valid), m_rdv[k]);
    check($sformatf("%s c%0d rd_stage", tag, k), int'(bus.rd_stage), m_rds[k]);
    check($sformatf("%s c%0d rd_beat",  tag, k), int'(bus.rd_beat),  m_rdb[k]);
    check($sformatf("%s c%0d wr_valid", tag, k), int'(bus.wr_valid), m_wrv[k]);
    check($sformatf("%s c%0d wr_stage", tag, k), int'(bus.wr_stage), m_wrs[k]);
    check($sformatf("%s c%0d busy",     tag, k), int'(bus.busy),     m_busy[k]);
    check($sformatf("%s c%0d done",     tag, k), int'(bus.done),     m_done[k]);
  endtask

  task automatic run_pass(input vec_t v, input string tag);
    int first_done;
    first_done = -1;
    build_model(v);
    for (int k = 0; k <= v.exp_done + 2; k++) begin
      @(negedge clk);
      bus.start = (k == 0 || k == v.repulse_cycle);
      bus.beats_per_stage = (k == 0) ? BEAT_W'(v.bps) :
                            (k == v.repulse_cycle) ? BEAT_W'(7) : BEAT_W'(0);
      bus.stall = m_stall[k][0];
      #1;
      check_outputs(tag, k);
      if (bus.done && first_done < 0) first_done = k;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    check($sformatf("%s done_cycle", tag), first_done, v.exp_done);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " rd_stage"}, int'(bus.rd_stage), 0);
    check({tag, " rd_beat"},  int'(bus.rd_beat),  0);
    check({tag, " rd_valid"}, int'(bus.rd_valid), 0);
    check({tag, " wr_stage"}, int'(bus.wr_stage), 0);
    check({tag, " wr_valid"}, int'(bus.wr_valid), 0);
    check({tag, " busy"},     int'(bus.busy),     0);
    check({tag, " done"},     int'(bus.done),     0);
  endtask

  vec_t vecs[5];

  initial begin
    // len=1; len=4 with 2-cycle stall at stage 5 beat 2 (44+2+3+1=50); bps=0 as len=1;
    // len=2 with ignored re-start at stage 3 (22+3+1=26); len=3 (33+3+1=37).
    vecs[0] = '{bps: 1, stall_stage: -1, stall_beat: -1, stall_cycles: 0, repulse_cycle: -1,
                exp_done: 15};
    vecs[1] = '{bps: 4, stall_stage: 5, stall_beat: 2, stall_cycles: 2, repulse_cycle: -1,
                exp_done: 50};
    vecs[2] = '{bps: 0, stall_stage: -1, stall_beat: -1, stall_cycles: 0, repulse_cycle: -1,
                exp_done: 15};
    vecs[3] = '{bps: 2, stall_stage: -1, stall_beat: -1, stall_cycles: 0, repulse_cycle: 7,
                exp_done: 26};
    vecs[4] = '{bps: 3, stall_stage: -1, stall_beat: -1, stall_cycles: 0, repulse_cycle: -1,
                exp_done: 37};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stall = 1'b0;
    bus.beats_per_stage = '0;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_idle("post_reset");

    for (int i = 0; i < 5; i++) begin
      run_pass(vecs[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Abort at rd_stage 6 (len=1 -> cycle 7).
    build_model(vecs[0]);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      bus.start = (k == 0);
      bus.beats_per_stage = BEAT_W'(1);
      bus.abort = (k == 7);
      #1;
      check_outputs("abort_pre", k);
    end
    for (int k = 8; k <= 22; k++) begin
      @(negedge clk);
      bus.abort = 1'b0;
      #1;
      if (k == 8) begin
        check_idle("abort_next");
      end else begin
        check($sformatf("abort c%0d wr_valid", k), int'(bus.wr_valid), 0);
        check($sformatf("abort c%0d done", k), int'(bus.done), 0);
        check($sformatf("abort c%0d busy", k), int'(bus.busy), 0);
      end
    end
    run_pass(vecs[0], "after_abort");
    repeat (2) @(negedge clk);

    // Abort beats start in idle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.beats_per_stage = BEAT_W'(1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1;
    check_idle("abort_vs_start");
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-DRAIN (len=1: drain on cycles 12..14).
    build_model(vecs[0]);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      bus.start = (k == 0);
      bus.beats_per_stage = BEAT_W'(1);
      #1;
      check_outputs("rst_pre", k);
    end
    #1;
    rst = 1'b1;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_after c%0d done", k), int'(bus.done), 0);
      check($sformatf("rst_after c%0d busy", k), int'(bus.busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
